// File: rtl/mask_writer_pkg.sv
// Shared types and constants for the mask writer: write-FSM states, burst geometry,
// FIFO depth and the luma-to-pattern threshold function.
package mask_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_t;

    localparam int BURST_LEN   = 16;
    localparam int BEAT_BYTES  = 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int FIFO_DEPTH  = 64;
    localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

    // Thermometer code: bit k set when luma reaches 128 + 16*k.
    function automatic logic [7:0] luma_pattern(input logic [9:0] luma);
        logic [7:0] pat;
        pat = '0;
        for (int k = 0; k < 8; k++) begin
            pat[k] = (luma >= 10'(128 + 16 * k));
        end
        return pat;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; rd_dat is valid whenever count != 0.
// A write is accepted when not full or when a read happens in the same cycle; flush empties it.
module sync_fifo
    import mask_writer_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign do_rd = rd_rdy && !empty;
    assign do_wr = wr_vld && (!full || do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

endmodule

// File: rtl/mask_writer.sv
// Converts video pixels to 8-bit luma threshold patterns, packs 8 per 64-bit word and writes them
// as 16-beat AXI bursts; pixel-to-FIFO push is 2 cycles, words are dropped (sticky flag) when the FIFO is full.
module mask_writer
    import mask_writer_pkg::*;
#(
    parameter int          H_WIDTH  = 1920,
    parameter int          V_HEIGHT = 1080,
    parameter logic [31:0] BASE     = 32'h21000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vin_vs_i,
    input  logic        vin_de_i,
    input  logic [23:0] data_i,
    output logic        overflow_o,
    output logic        err_o,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [3:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic [1:0]  m_axi_awlock,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic [3:0]  m_axi_awqos,
    output logic [5:0]  m_axi_awid,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [63:0] m_axi_wdata,
    output logic        m_axi_wlast,
    output logic [5:0]  m_axi_wid,
    output logic [7:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    input  logic [5:0]  m_axi_bid
);

    localparam int          TOTAL     = H_WIDTH * V_HEIGHT;
    localparam logic [31:0] LAST_ADDR = BASE + 32'(TOTAL - BURST_BYTES);

    assign m_axi_awlen   = 4'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 2'b00;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awid    = 6'd0;
    assign m_axi_wid     = 6'd0;
    assign m_axi_wstrb   = 8'hFF;

    logic bid_unused;
    assign bid_unused = ^m_axi_bid;

    // Pixel front end: luma register and frame-start detection
    logic [9:0] luma_sum;
    logic [9:0] luma_q;
    logic       de_q;
    logic       vs_q;
    logic       vs_rise;

    assign luma_sum = 10'(data_i[23:16]) + {1'b0, data_i[15:8], 1'b0} + 10'(data_i[7:0]);
    assign vs_rise  = vin_vs_i && !vs_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_q   <= 1'b0;
            vs_q   <= 1'b0;
            luma_q <= '0;
        end else begin
            de_q <= vin_de_i;
            vs_q <= vin_vs_i;
            if (vin_de_i) luma_q <= luma_sum >> 2;
        end
    end

    // Byte packer; a pixel coinciding with a frame start belongs to the old frame and is dropped
    logic [31:0] pix_cnt;
    logic [2:0]  byte_idx;
    logic [55:0] pack_q;
    logic [7:0]  pat;
    logic        pix_take;
    logic        push_vld;
    logic [63:0] push_dat;

    assign pat      = luma_pattern(luma_q);
    assign pix_take = de_q && !vs_rise && (pix_cnt < 32'(TOTAL));
    assign push_vld = pix_take && (byte_idx == 3'd7);
    assign push_dat = {pat, pack_q};

    always_ff @(posedge clk_i) begin
        if (rst_i || vs_rise) begin
            pix_cnt  <= '0;
            byte_idx <= '0;
            pack_q   <= '0;
        end else if (pix_take) begin
            pix_cnt  <= pix_cnt + 32'd1;
            byte_idx <= byte_idx + 3'd1;
            for (int b = 0; b < 7; b++) begin
                if (byte_idx == 3'(b)) pack_q[8*b +: 8] <= pat;
            end
        end
    end

    wr_state_t               state_q;
    wr_state_t               state_d;
    logic [3:0]              beat_q;
    logic [31:0]             addr_q;
    logic                    restart_pend_q;
    logic                    restart_req;
    logic                    do_restart;
    logic                    pop;
    logic                    fifo_full;
    logic [FIFO_CNT_W-1:0]   fifo_cnt;
    logic [63:0]             fifo_dat;

    sync_fifo #(
        .WIDTH (8 * BEAT_BYTES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush  (do_restart),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .rd_rdy (pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .count  (fifo_cnt)
    );

    // A frame start can only retarget the buffer between bursts, never mid-burst
    assign restart_req = vs_rise || restart_pend_q;
    assign do_restart  = restart_req &&
                         ((state_q == ST_IDLE) || (state_q == ST_B && m_axi_bvalid));
    assign pop         = (state_q == ST_W) && m_axi_wready;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fifo_cnt >= FIFO_CNT_W'(BURST_LEN) && !restart_req) state_d = ST_AW;
            ST_AW:   if (m_axi_awready) state_d = ST_W;
            ST_W:    if (m_axi_wready && beat_q == 4'(BURST_LEN - 1)) state_d = ST_B;
            ST_B:    if (m_axi_bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = (state_q == ST_AW);
        m_axi_wvalid  = (state_q == ST_W);
        m_axi_wlast   = (state_q == ST_W) && (beat_q == 4'(BURST_LEN - 1));
        m_axi_bready  = (state_q == ST_B);
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_wdata  = fifo_dat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q         <= '0;
            addr_q         <= BASE;
            restart_pend_q <= 1'b0;
            overflow_o     <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            if (state_q == ST_AW && m_axi_awready) beat_q <= '0;
            else if (pop)                          beat_q <= beat_q + 4'd1;

            if (do_restart) begin
                addr_q <= BASE;
            end else if (state_q == ST_AW && m_axi_awready) begin
                addr_q <= (addr_q == LAST_ADDR) ? BASE : addr_q + 32'(BURST_BYTES);
            end

            if (do_restart)   restart_pend_q <= 1'b0;
            else if (vs_rise) restart_pend_q <= 1'b1;

            if (push_vld && fifo_full && !pop && !do_restart) overflow_o <= 1'b1;
            if (state_q == ST_B && m_axi_bvalid && m_axi_bresp != 2'b00) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mask_writer.sv
// Directed bench for mask_writer with a 32x24 frame (768 pixels, 6 bursts per frame).
module tb_mask_writer;

    localparam logic [31:0] BASE = 32'h21000000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        vin_vs_i;
    logic        vin_de_i;
    logic [23:0] data_i;
    logic        overflow_o;
    logic        err_o;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [3:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [1:0]  m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic [5:0]  m_axi_awid;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [63:0] m_axi_wdata;
    logic        m_axi_wlast;
    logic [5:0]  m_axi_wid;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic [5:0]  m_axi_bid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] aw_log [$];
    logic [63:0] wd_log [$];
    int          wlast_pos [$];
    int          viol = 0;
    logic        prev_stall;
    logic [31:0] prev_awaddr;
    logic [23:0] pat_px [8];

    always #5 clk_i = ~clk_i;

    mask_writer #(
        .H_WIDTH  (32),
        .V_HEIGHT (24),
        .BASE     (BASE)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .vin_vs_i      (vin_vs_i),
        .vin_de_i      (vin_de_i),
        .data_i        (data_i),
        .overflow_o    (overflow_o),
        .err_o         (err_o),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awqos   (m_axi_awqos),
        .m_axi_awid    (m_axi_awid),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wid     (m_axi_wid),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bid     (m_axi_bid)
    );

    // Slave answers every response request immediately
    assign m_axi_bvalid = m_axi_bready;
    assign m_axi_bid    = 6'd0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) viol++;
            prev_stall  <= m_axi_awvalid && !m_axi_awready;
            prev_awaddr <= m_axi_awaddr;
            if (m_axi_awvalid && m_axi_awready) aw_log.push_back(m_axi_awaddr);
            if (m_axi_wvalid && m_axi_wready) begin
                wd_log.push_back(m_axi_wdata);
                if (m_axi_wlast) wlast_pos.push_back(wd_log.size());
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pixels(input int n, input logic [23:0] d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            vin_de_i = 1'b1;
            data_i   = d;
        end
        @(negedge clk_i);
        vin_de_i = 1'b0;
    endtask

    task automatic pattern_pixels(input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk_i);
                vin_de_i = 1'b1;
                data_i   = pat_px[i];
            end
        end
        @(negedge clk_i);
        vin_de_i = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk_i);
        vin_vs_i = 1'b1;
        @(negedge clk_i);
        vin_vs_i = 1'b0;
    endtask

    task automatic clear_logs();
        aw_log.delete();
        wd_log.delete();
        wlast_pos.delete();
    endtask

    task automatic wait_beats(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (wd_log.size() < n && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
        end
        repeat (4) @(negedge clk_i);
        chk(tag, 64'(wd_log.size()), 64'(n));
    endtask

    task automatic wait_wvalid(input string tag);
        int cyc;
        cyc = 0;
        while (!m_axi_wvalid && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        chk(tag, 64'(m_axi_wvalid), 64'd1);
    endtask

    initial begin
        pat_px[0] = 24'hC8C8C8;  // luma 200 -> 1F
        pat_px[1] = 24'h7F7F7F;  // luma 127 -> 00
        pat_px[2] = 24'hF0F0F0;  // luma 240 -> FF
        pat_px[3] = 24'h808080;  // luma 128 -> 01
        pat_px[4] = 24'h8F8F8F;  // luma 143 -> 01
        pat_px[5] = 24'h909090;  // luma 144 -> 03
        pat_px[6] = 24'h1080F0;  // (16+256+240)/4 = 128 -> 01
        pat_px[7] = 24'hFFFFFF;  // luma 255 -> FF

        rst_i         = 1'b1;
        vin_vs_i      = 1'b0;
        vin_de_i      = 1'b0;
        data_i        = '0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bresp   = 2'b00;
        repeat (3) @(negedge clk_i);

        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_wlast", 64'(m_axi_wlast), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'(BASE));
        chk("const_awlen", 64'(m_axi_awlen), 64'd15);
        chk("const_awsize", 64'(m_axi_awsize), 64'd3);
        chk("const_awburst", 64'(m_axi_awburst), 64'd1);
        chk("const_awcache", 64'(m_axi_awcache), 64'd3);
        chk("const_wstrb", 64'(m_axi_wstrb), 64'hFF);
        rst_i = 1'b0;
        vs_pulse();

        // White pixels: one burst at BASE, all-ones beats, wlast on beat 16 only
        clear_logs();
        pixels(128, 24'hFFFFFF);
        wait_beats(16, "white_beats");
        chk("white_aw_cnt", 64'(aw_log.size()), 64'd1);
        chk("white_awaddr", 64'(aw_log[0]), 64'(BASE));
        for (int i = 0; i < 16; i++) chk("white_wdata", wd_log[i], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("white_wlast_cnt", 64'(wlast_pos.size()), 64'd1);
        chk("white_wlast_pos", 64'(wlast_pos[0]), 64'd16);

        // Threshold patterns packed little-endian by pixel index
        clear_logs();
        pattern_pixels(16);
        wait_beats(16, "pat_beats");
        chk("pat_awaddr", 64'(aw_log[0]), 64'(BASE + 32'd128));
        chk("pat_wdata0", wd_log[0], 64'hFF01_0301_01FF_001F);
        chk("pat_wdata15", wd_log[15], 64'hFF01_0301_01FF_001F);

        // Rest of the frame, then surplus pixels that must not be written
        clear_logs();
        pixels(512, 24'h808080);
        pixels(200, 24'hFFFFFF);
        wait_beats(64, "frame_beats");
        repeat (60) @(negedge clk_i);
        chk("frame_no_extra", 64'(wd_log.size()), 64'd64);
        chk("frame_aw_cnt", 64'(aw_log.size()), 64'd4);
        chk("frame_last_addr", 64'(aw_log[3]), 64'(BASE + 32'd640));
        chk("frame_wdata", wd_log[63], 64'h0101_0101_0101_0101);
        chk("frame_awaddr_wrap", 64'(m_axi_awaddr), 64'(BASE));

        vs_pulse();
        clear_logs();
        pixels(128, 24'hFFFFFF);
        wait_beats(16, "nextframe_beats");
        chk("nextframe_awaddr", 64'(aw_log[0]), 64'(BASE));

        // Slave stalls the address channel while 75 words arrive: 11 dropped
        vs_pulse();
        clear_logs();
        m_axi_awready = 1'b0;
        pixels(600, 24'hFFFFFF);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_awvalid_held", 64'(m_axi_awvalid), 64'd1);
        chk("ovf_no_aw", 64'(aw_log.size()), 64'd0);
        m_axi_awready = 1'b1;
        wait_beats(64, "ovf_drain_beats");
        repeat (40) @(negedge clk_i);
        chk("ovf_no_extra", 64'(wd_log.size()), 64'd64);
        chk("ovf_first_addr", 64'(aw_log[0]), 64'(BASE));
        chk("ovf_last_addr", 64'(aw_log[3]), 64'(BASE + 32'd384));
        chk("ovf_protocol", 64'(viol), 64'd0);

        // Frame start during the data phase, error response on that burst
        vs_pulse();
        clear_logs();
        m_axi_awready = 1'b0;
        pixels(192, 24'hFFFFFF);
        m_axi_bresp   = 2'b10;
        m_axi_awready = 1'b1;
        wait_wvalid("vsw_wvalid");
        vs_pulse();
        wait_beats(16, "vsw_beats");
        chk("vsw_wlast_pos", 64'(wlast_pos[0]), 64'd16);
        chk("vsw_err", 64'(err_o), 64'd1);
        m_axi_bresp = 2'b00;
        clear_logs();
        pixels(128, 24'h808080);
        wait_beats(16, "vsw_next_beats");
        chk("vsw_next_awaddr", 64'(aw_log[0]), 64'(BASE));
        chk("vsw_next_wdata", wd_log[0], 64'h0101_0101_0101_0101);
        chk("vsw_err_sticky", 64'(err_o), 64'd1);

        // Reset in the middle of a burst abandons it
        clear_logs();
        pixels(128, 24'hFFFFFF);
        wait_wvalid("rstw_wvalid");
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstw_wvalid_low", 64'(m_axi_wvalid), 64'd0);
        chk("rstw_err_clr", 64'(err_o), 64'd0);
        chk("rstw_ovf_clr", 64'(overflow_o), 64'd0);
        chk("rstw_awaddr", 64'(m_axi_awaddr), 64'(BASE));
        rst_i = 1'b0;
        repeat (30) @(negedge clk_i);
        chk("rstw_no_beats", 64'(wd_log.size()), 64'd0);
        chk("rstw_idle", 64'(m_axi_awvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mask_writer.md
MASK_WRITER -- requirements
Module: mask_writer

Interface
REQ-001 SHALL have parameter H_WIDTH, default 1920, active pixels per line.
REQ-002 SHALL have parameter V_HEIGHT, default 1080, active lines per frame; H_WIDTH*V_HEIGHT SHALL be a multiple of 128.
REQ-003 SHALL have parameter BASE, default 32'h21000000, byte address of pattern buffer (128-byte aligned).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  pixel/AXI clock; rst_i  in  1  synchronous active-high reset.
REQ-005 vin_vs_i  in  1  vertical sync; rising edge marks frame start.
REQ-006 vin_de_i  in  1  data enable; one active pixel per high cycle.
REQ-007 data_i  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 overflow_o  out  1  sticky: a packed word was dropped on a full FIFO.
REQ-009 err_o  out  1  sticky: a write response with bresp != 0 was received.
REQ-010 m_axi_awvalid/awready  out/in  1  write-address handshake; m_axi_awaddr  out  32  burst address.
REQ-011 m_axi_wvalid/wready  out/in  1  write-data handshake; m_axi_wdata  out  64; m_axi_wlast  out  1.
REQ-012 m_axi_bvalid/bready  in/out  1  response handshake; m_axi_bresp  in  2; m_axi_bid  in  6 (ignored).
REQ-013 Constant outputs: awlen(4)=15, awsize(3)=3, awburst(2)=1 INCR, awlock(2)=0, awcache(4)=4'b0011, awprot(3)=0, awqos(4)=0, awid(6)=0, wid(6)=0, wstrb(8)=8'hFF.

Function
REQ-014 Luma SHALL be (R + 2G + B) >> 2, computed in 10 bits, registered one cycle after vin_de_i.
REQ-015 Pattern byte bit k (k=0..7) SHALL be 1 when luma >= 128 + 16*k (thresholds 128..240).
REQ-016 Pixel n of the frame SHALL occupy wdata bits [8*(n%8)+7 : 8*(n%8)] of word n/8; a word SHALL be pushed to the FIFO on its 8th byte.
REQ-017 Pixels beyond H_WIDTH*V_HEIGHT in a frame SHALL be discarded, never written.
REQ-018 A push when the FIFO is full SHALL drop the word and set overflow_o.
REQ-019 Write FSM states: IDLE, AW, W, B.
REQ-020 IDLE->AW when FIFO holds >= 16 words and no restart is pending; AW holds awvalid=1 and stable awaddr until awready.
REQ-021 AW->W on awready; W asserts wvalid with wdata = FIFO head, pops on wvalid&wready, wlast=1 on beat 15 only.
REQ-022 W->B after beat-15 handshake; B asserts bready=1; B->IDLE on bvalid, setting err_o if bresp != 0.
REQ-023 awaddr SHALL start at BASE each frame and advance 128 per accepted burst; never exceed BASE + H_WIDTH*V_HEIGHT - 128.
REQ-024 On vin_vs_i rising edge: pixel counter and byte packer SHALL clear immediately (partial word discarded); if FSM is IDLE, FIFO SHALL flush and awaddr reset to BASE the next cycle, else a restart is pended and executed on the B->IDLE transition.
REQ-025 Latency: pixel-to-FIFO-push of the completing byte SHALL be 2 cycles.
REQ-026 Simultaneous push and pop SHALL both take effect; a full FIFO popped and pushed in one cycle SHALL not overflow.

Reset
REQ-027 On rst_i=1 at a clock edge: FSM=IDLE, FIFO empty, counters 0, awaddr=BASE, awvalid=wvalid=wlast=bready=0, overflow_o=err_o=0.
REQ-028 Reset mid-burst SHALL abandon the burst immediately without completing outstanding beats.

Structure
REQ-029 FSM state encoding, burst length 16, beat bytes 8 and FIFO depth 64 SHALL live in the shared package.
REQ-030 FIFO SHALL be a separate sub-module sync_fifo (64-bit x 64, first-word-fall-through, count output).

Verification
REQ-031 128 pixels of data_i=24'hFFFFFF, always-ready slave -> one burst at 32'h21000000, 16 beats of wdata=64'hFFFF_FFFF_FFFF_FFFF, wlast on beat 16.
REQ-032 Pixel luma 200 (R=G=B=200) -> pattern byte 8'h1F; luma 127 -> 8'h00; luma 240 -> 8'hFF.
REQ-033 Full frame, H_WIDTH=16, V_HEIGHT=8 -> exactly one burst per 128 pixels, final awaddr 32'h21000000; next frame restarts at BASE.
REQ-034 awready held 0 while 600 pixels stream -> FIFO fills at 64 words, overflow_o=1, no AXI protocol violation.
REQ-035 vin_vs_i rise during W state -> burst completes 16 beats, then FIFO flushed, next burst addressed at BASE; bresp=2'b10 sets err_o=1.
